serial_alu: RTL and testbench

- Parametrised, multi-cycle successor to the single-bit ALU slice.
- Processes a WIDTH-bit operation DIGIT bits per clock, LSB first, through one combinational digit slice.
- Uses valid/ready handshakes on input and output.
- Supports AND, OR, ADD, SUB and SLT with the existing 3-bit opcode encoding, and adds zero/carry/overflow/illegal-op flags.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_digit_slice.sv | 38 +++
 rtl/serial_alu.sv | 140 ++++++++++++++
 tb/tb_serial_alu.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode, state and decode definitions
// for the digit-serial ALU.
package alu_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic legal_op(input logic [2:0] op);
    logic ok;
    ok = 1'b0;
    unique case (1'b1)
      (op == OP_AND): ok = 1'b1;
      (op == OP_OR):  ok = 1'b1;
      (op == OP_ADD): ok = 1'b1;
      (op == OP_SUB): ok = 1'b1;
      (op == OP_SLT): ok = 1'b1;
      default:        ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/alu_digit_slice.sv
// Combinational DIGIT-bit ripple slice: logic ops or
// add/sub with carry chain and carry-into-top-bit export.
module alu_digit_slice
  import alu_pkg::*;
#(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a_d,
  input  logic [DIGIT-1:0] b_d,
  input  logic             cin,
  input  logic [2:0]       op,
  output logic [DIGIT-1:0] r_d,
  output logic             cout,
  output logic             c_msb
);

  logic c;
  logic bx;

  always_comb begin
    c     = cin;
    c_msb = cin;
    bx    = 1'b0;
    r_d   = '0;
    for (int i = 0; i < DIGIT; i++) begin
      if (i == DIGIT - 1) c_msb = c;
      bx = b_d[i] ^ op[2];
      unique case (1'b1)
        (op == OP_AND): r_d[i] = a_d[i] & b_d[i];
        (op == OP_OR):  r_d[i] = a_d[i] | b_d[i];
        default:        r_d[i] = a_d[i] ^ bx ^ c;
      endcase
      c = (a_d[i] & bx) | (c & (a_d[i] ^ bx));
    end
    cout = c;
  end

endmodule

// File: rtl/serial_alu.sv
// Digit-serial ALU: LSB-first, DIGIT bits per cycle,
// valid/ready on both sides, registered result and flags.
module serial_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             zero,
  output logic             op_err
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = $clog2(N + 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] r_sh;
  logic [2:0]       op_r;
  logic             carry;
  logic             c_msb_r;

  logic [DIGIT-1:0] r_d;
  logic             s_cout;
  logic             s_msb;

  alu_digit_slice #(.DIGIT(DIGIT)) u_slice (
    .a_d   (a_sh[DIGIT-1:0]),
    .b_d   (b_sh[DIGIT-1:0]),
    .cin   (carry),
    .op    (op_r),
    .r_d   (r_d),
    .cout  (s_cout),
    .c_msb (s_msb)
  );

  logic             legal;
  logic             ovf_raw;
  logic             less;
  logic [WIDTH-1:0] res_n;
  logic             cout_n;
  logic             ovf_n;

  // Flag and result finalisation from the completed shift state.
  always_comb begin
    legal   = legal_op(op_r);
    ovf_raw = carry ^ c_msb_r;
    less    = r_sh[WIDTH-1] ^ ovf_raw;
    res_n   = r_sh;
    cout_n  = 1'b0;
    ovf_n   = 1'b0;
    unique case (1'b1)
      (!legal): res_n = '0;
      (op_r == OP_SLT): res_n = WIDTH'(less);
      (op_r == OP_ADD),
      (op_r == OP_SUB): begin
        cout_n = carry;
        ovf_n  = ovf_raw;
      end
      default: res_n = r_sh;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      a_sh      <= '0;
      b_sh      <= '0;
      r_sh      <= '0;
      op_r      <= '0;
      carry     <= 1'b0;
      c_msb_r   <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      cout      <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
      op_err    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh     <= a;
            b_sh     <= b;
            op_r     <= op;
            carry    <= op[2];
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          // Extra count step loads the output registers.
          if (cnt == CW'(N)) begin
            result    <= res_n;
            cout      <= cout_n;
            overflow  <= ovf_n;
            zero      <= (res_n == '0);
            op_err    <= !legal;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            a_sh    <= a_sh >> DIGIT;
            b_sh    <= b_sh >> DIGIT;
            r_sh    <= (r_sh >> DIGIT)
                     | (WIDTH'(r_d) << (WIDTH - DIGIT));
            carry   <= s_cout;
            c_msb_r <= s_msb;
            cnt     <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_alu.sv
// Scoreboard bench for serial_alu: 8-bit/1-digit and
// 32-bit/4-digit instances against an arithmetic model.
module tb_serial_alu;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic       iv8, ir8, ov8, or8;
  logic [7:0] a8, b8, r8;
  logic [2:0] op8;
  logic       c8, v8, z8, e8;

  logic        iv32, ir32, ov32, or32;
  logic [31:0] a32, b32, r32;
  logic [2:0]  op32;
  logic        c32, v32, z32, e32;

  serial_alu #(.WIDTH(8), .DIGIT(1)) u8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv8), .in_ready(ir8),
    .a(a8), .b(b8), .op(op8),
    .out_valid(ov8), .out_ready(or8),
    .result(r8), .cout(c8), .overflow(v8),
    .zero(z8), .op_err(e8)
  );

  serial_alu #(.WIDTH(32), .DIGIT(4)) u32 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv32), .in_ready(ir32),
    .a(a32), .b(b32), .op(op32),
    .out_valid(ov32), .out_ready(or32),
    .result(r32), .cout(c32), .overflow(v32),
    .zero(z32), .op_err(e32)
  );

  typedef struct packed {
    logic [31:0] r;
    logic c, v, z, e;
  } exp_t;

  exp_t q8[$];
  exp_t q32[$];
  int compared = 0;
  int mismatched = 0;

  // Reference: plain integer arithmetic on WIDTH-bit values.
  function automatic exp_t model(input int w, input logic [31:0] a,
                                 input logic [31:0] b, input logic [2:0] op);
    longint m, ua, ub, sa, sb, s, lo, hi;
    exp_t x;
    m  = (longint'(1) << w) - 1;
    ua = longint'(a) & m;
    ub = longint'(b) & m;
    sa = ((ua >> (w - 1)) != 0) ? ua - (m + 1) : ua;
    sb = ((ub >> (w - 1)) != 0) ? ub - (m + 1) : ub;
    lo = -(longint'(1) << (w - 1));
    hi = -lo - 1;
    x = '0;
    case (op)
      3'b000: x.r = 32'(ua & ub);
      3'b001: x.r = 32'(ua | ub);
      3'b010: begin
        s = ua + ub;
        x.r = 32'(s & m);
        x.c = (s > m);
        x.v = (sa + sb < lo) || (sa + sb > hi);
      end
      3'b110: begin
        x.r = 32'((ua - ub) & m);
        x.c = (ua >= ub);
        x.v = (sa - sb < lo) || (sa - sb > hi);
      end
      3'b111: x.r = 32'(sa < sb);
      default: x.e = 1'b1;
    endcase
    x.z = (x.r == 0);
    return x;
  endfunction

  task automatic chk(input string nm, input exp_t got, input exp_t want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s: got r=%h c=%b v=%b z=%b e=%b want r=%h c=%b v=%b z=%b e=%b",
               nm, got.r, got.c, got.v, got.z, got.e,
               want.r, want.c, want.v, want.z, want.e);
    end
  endtask

  task automatic chk_int(input string nm, input longint got, input longint want);
    compared++;
    if (got != want) begin
      mismatched++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && ov8 && or8) begin
      if (q8.size() == 0) chk_int("u8_unexpected_output", 1, 0);
      else chk("u8_result", {24'h0, r8, c8, v8, z8, e8}, q8.pop_front());
    end
  end

  always @(negedge clk) begin
    if (rst_n && ov32 && or32) begin
      if (q32.size() == 0) chk_int("u32_unexpected_output", 1, 0);
      else chk("u32_result", {r32, c32, v32, z32, e32}, q32.pop_front());
    end
  end

  task automatic issue8(input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] op, input bit lat);
    int n;
    n = 0;
    while (!ir8 && n < 200) begin @(posedge clk); #1; n++; end
    if (!ir8) chk_int("u8_ready_timeout", 0, 1);
    a8 = a; b8 = b; op8 = op; iv8 = 1'b1;
    @(posedge clk);
    q8.push_back(model(8, {24'h0, a}, {24'h0, b}, op));
    #1;
    iv8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); op8 = 3'($urandom);
    n = 0;
    while (!ov8 && n < 50) begin @(posedge clk); #1; n++; end
    if (lat) chk_int("u8_latency", n, 9);
  endtask

  task automatic issue32(input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] op, input bit lat);
    int n;
    n = 0;
    while (!ir32 && n < 200) begin @(posedge clk); #1; n++; end
    if (!ir32) chk_int("u32_ready_timeout", 0, 1);
    a32 = a; b32 = b; op32 = op; iv32 = 1'b1;
    @(posedge clk);
    q32.push_back(model(32, a, b, op));
    #1;
    iv32 = 1'b0; a32 = $urandom; b32 = $urandom; op32 = 3'($urandom);
    n = 0;
    while (!ov32 && n < 50) begin @(posedge clk); #1; n++; end
    if (lat) chk_int("u32_latency", n, 9);
  endtask

  logic [11:0] snap;

  initial begin
    iv8 = 0; or8 = 1; a8 = 0; b8 = 0; op8 = 0;
    iv32 = 0; or32 = 1; a32 = 0; b32 = 0; op32 = 0;
    #1 rst_n = 1'b0;
    #2;
    chk_int("u8_reset_state", {ir8, ov8, r8, c8, v8, z8, e8}, 14'h2000);
    chk_int("u32_reset_state", {ir32, ov32, r32, c32, v32, z32, e32}, 38'h20_0000_0000);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    issue8(8'hFF, 8'h01, 3'b010, 1);
    issue8(8'h80, 8'h01, 3'b110, 0);
    issue8(8'h01, 8'h02, 3'b110, 0);
    issue8(8'h80, 8'h01, 3'b111, 0);
    issue8(8'h01, 8'h80, 3'b111, 0);
    issue8(8'h05, 8'h05, 3'b111, 0);
    issue8(8'h3C, 8'h5A, 3'b100, 1);

    issue32(32'hF0F0_1234, 32'h0FF0_FFFF, 3'b000, 1);
    issue32(32'hF0F0_1234, 32'h0FF0_FFFF, 3'b001, 0);
    issue32(32'hF0F0_1234, 32'h0FF0_FFFF, 3'b011, 1);
    issue32(32'h7FFF_FFFF, 32'h0000_0001, 3'b010, 0);
    issue32(32'h8000_0000, 32'h0000_0001, 3'b111, 0);

    for (int i = 0; i < 30; i++) begin
      issue8(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)), 0);
      issue32($urandom, $urandom, 3'($urandom_range(0, 7)), 0);
    end

    // Backpressure hold with an ignored in_valid pulse.
    @(posedge clk); #1;
    or8 = 1'b0;
    issue8(8'h12, 8'h34, 3'b010, 1);
    snap = {r8, c8, v8, z8, e8};
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin a8 = 8'hAA; b8 = 8'h55; op8 = 3'b001; iv8 = 1'b1; end
      @(posedge clk); #1;
      iv8 = 1'b0;
      chk_int("bp_out_valid", ov8, 1);
      chk_int("bp_in_ready", ir8, 0);
      chk_int("bp_hold", {r8, c8, v8, z8, e8}, snap);
    end
    or8 = 1'b1;
    @(posedge clk); #1;
    chk_int("bp_release_in_ready", ir8, 1);
    chk_int("bp_release_out_valid", ov8, 0);

    // Reset during digit 3 of an ADD.
    repeat (12) @(posedge clk);
    #1;
    a8 = 8'h11; b8 = 8'h22; op8 = 3'b010; iv8 = 1'b1;
    @(posedge clk); #1 iv8 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk_int("mid_run_reset", {ir8, ov8, r8, c8, v8, z8, e8}, 14'h2000);
    @(posedge clk); #1 rst_n = 1'b1;
    issue8(8'h7F, 8'h01, 3'b010, 1);

    repeat (4) @(posedge clk);
    #1;
    chk_int("u8_queue_drained", q8.size(), 0);
    chk_int("u32_queue_drained", q32.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
